// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the CPU MEM stage and an
// accelerator/DMA burst requester. The CPU owns the memory by default and
// passes through combinationally. The accelerator is granted the memory for
// a burst of up to MAX_BURST beats. While it holds the grant, the CPU is
// stalled if it tries to access memory.
//
// Build option:
//   DMEM_ARB_STARVE_EN - when defined, a starvation counter forces a grant
//                        after STARVE_LIMIT blocked request cycles. When it
//                        is undefined, the accelerator is granted only in
//                        cycles where the CPU makes no access.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cpu_rd/cpu_wr         MEM-stage strobes; cpu_addr, cpu_wdata
//   cpu_rdata, cpu_stall  read data back to MEM stage, pipeline hold
//   acc_req, acc_wr       burst request (held), beat direction
//   acc_addr, acc_wdata   per-beat address/data; acc_len burst length
//   acc_gnt, acc_ack      accelerator owns memory, beat accepted
//   acc_rdata, acc_rvalid registered read data, valid one cycle after beat
//   acc_done              pulse on the final beat
//   mem_rd/mem_wr, mem_addr, mem_wdata, mem_rdata   data memory port
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW           = 7,
    parameter int DW           = 32,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          acc_req,
    input  logic          acc_wr,
    input  logic [AW-1:0] acc_addr,
    input  logic [DW-1:0] acc_wdata,
    input  logic [3:0]    acc_len,
    output logic          acc_gnt,
    output logic          acc_ack,
    output logic [DW-1:0] acc_rdata,
    output logic          acc_rvalid,
    output logic          acc_done,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam logic [3:0] MAX_LEN = 4'(MAX_BURST);

    logic [0:0] state;
    logic [3:0] len;
    logic [3:0] beat_cnt;
    logic [3:0] len_clamped;
    logic       cpu_access;
    logic       grant;
    logic       beat;
    logic       last_beat;

    assign cpu_access = cpu_rd | cpu_wr;
    assign beat       = (state == BURST) && acc_req;
    assign last_beat  = beat && (beat_cnt == len - 4'd1);

    // A zero length still moves one beat; over-long bursts are cut to MAX_LEN.
    always_comb begin
        if (acc_len == 4'd0)
            len_clamped = 4'd1;
        else if (acc_len > MAX_LEN)
            len_clamped = MAX_LEN;
        else
            len_clamped = acc_len;
    end

`ifdef DMEM_ARB_STARVE_EN
    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;

    // The CPU access in the grant cycle still passes through in IDLE, so a
    // forced grant never drops a CPU transfer.
    assign grant = (state == IDLE) && acc_req &&
                   (!cpu_access || (starve_cnt == STARVE_MAX));

    // Counts IDLE cycles where the accelerator waited behind a CPU access.
    // It is zero whenever IDLE is re-entered, so the CPU always gets at
    // least one cycle after a burst.
    always_ff @(posedge clk) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if ((state != IDLE) || !acc_req || grant)
            starve_cnt <= '0;
        else if (cpu_access && (starve_cnt != STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign grant = (state == IDLE) && acc_req && !cpu_access;
`endif

    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;
        cpu_stall = 1'b0;
        acc_gnt   = 1'b0;
        acc_ack   = 1'b0;
        acc_done  = 1'b0;
        if (state == BURST) begin
            mem_rd    = beat & ~acc_wr;
            mem_wr    = beat & acc_wr;
            mem_addr  = acc_addr;
            mem_wdata = acc_wdata;
            cpu_rdata = '0;
            cpu_stall = cpu_access;
            acc_gnt   = 1'b1;
            acc_ack   = beat;
            acc_done  = last_beat;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            len        <= 4'd0;
            beat_cnt   <= 4'd0;
            acc_rdata  <= '0;
            acc_rvalid <= 1'b0;
        end else begin
            // Read data is captured on the beat and presented one cycle
            // later, including after the final beat when already in IDLE.
            acc_rvalid <= beat & ~acc_wr;
            if (beat && !acc_wr)
                acc_rdata <= mem_rdata;

            case (state)
                IDLE: begin
                    if (grant) begin
                        state    <= BURST;
                        len      <= len_clamped;
                        beat_cnt <= 4'd0;
                    end
                end
                BURST: begin
                    if (beat)
                        beat_cnt <= beat_cnt + 4'd1;
                    // Dropping acc_req aborts without a done pulse.
                    if (!acc_req || last_beat)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with a behavioural single-port data
// memory (combinational read, write on posedge). Inputs change 1 time unit
// after posedge; outputs are checked on the falling edge. The starvation
// section expects the behaviour selected by DMEM_ARB_STARVE_EN.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          cpu_rd;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          acc_req;
    logic          acc_wr;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic [3:0]    acc_len;
    logic          acc_gnt;
    logic          acc_ack;
    logic [DW-1:0] acc_rdata;
    logic          acc_rvalid;
    logic          acc_done;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] dm [2**AW];

    int total;
    int bad;

    dmem_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(8), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .acc_req(acc_req), .acc_wr(acc_wr), .acc_addr(acc_addr),
        .acc_wdata(acc_wdata), .acc_len(acc_len), .acc_gnt(acc_gnt),
        .acc_ack(acc_ack), .acc_rdata(acc_rdata), .acc_rvalid(acc_rvalid),
        .acc_done(acc_done), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory.
    always @(posedge clk)
        if (mem_wr) dm[mem_addr] <= mem_wdata;
    assign mem_rdata = dm[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        acc_req   = 1'b0;
        acc_wr    = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;
        acc_len   = 4'd0;

        // Reset state.
        next_cycle();
        next_cycle();
        sample();
        check("rst_gnt",    32'(acc_gnt),    32'd0);
        check("rst_rvalid", 32'(acc_rvalid), 32'd0);
        check("rst_rdata",  acc_rdata,       32'd0);
        check("rst_stall",  32'(cpu_stall),  32'd0);
        check("rst_ack",    32'(acc_ack),    32'd0);

        // CPU pass-through: preload 0x20/0x21 and read one back.
        next_cycle();
        rst_n = 1'b1; cpu_wr = 1'b1; cpu_addr = 7'h20; cpu_wdata = 32'h55;
        sample();
        check("pre_mem_wr", 32'(mem_wr),   32'd1);
        check("pre_addr",   32'(mem_addr), 32'h20);
        check("pre_stall",  32'(cpu_stall), 32'd0);
        next_cycle();
        cpu_addr = 7'h21; cpu_wdata = 32'h66;
        sample();
        check("pre_wdata", mem_wdata, 32'h66);
        next_cycle();
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 7'h20;
        sample();
        check("pre_rd", cpu_rdata, 32'h55);

        // Write burst, len 4, to 0x10..0x13 with 0xA0..0xA3.
        next_cycle();
        cpu_rd = 1'b0;
        acc_req = 1'b1; acc_wr = 1'b1; acc_len = 4'd4;
        acc_addr = 7'h10; acc_wdata = 32'hA0;
        sample();
        check("wb_req_gnt", 32'(acc_gnt), 32'd0);
        check("wb_req_ack", 32'(acc_ack), 32'd0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            acc_addr  = 7'h10 + 7'(i);
            acc_wdata = 32'hA0 + 32'(i);
            sample();
            check("wb_gnt",    32'(acc_gnt),  32'd1);
            check("wb_ack",    32'(acc_ack),  32'd1);
            check("wb_mem_wr", 32'(mem_wr),   32'd1);
            check("wb_addr",   32'(mem_addr), 32'h10 + 32'(i));
            check("wb_done",   32'(acc_done), (i == 3) ? 32'd1 : 32'd0);
        end
        next_cycle();
        acc_req = 1'b0;
        sample();
        check("wb_after_gnt", 32'(acc_gnt), 32'd0);
        next_cycle();
        cpu_rd = 1'b1; cpu_addr = 7'h12;
        sample();
        check("wb_lw_0x12", cpu_rdata, 32'hA2);

        // Read burst, len 2, from 0x20/0x21.
        next_cycle();
        cpu_rd = 1'b0;
        acc_req = 1'b1; acc_wr = 1'b0; acc_len = 4'd2; acc_addr = 7'h20;
        sample();
        check("rb_req_gnt", 32'(acc_gnt), 32'd0);
        next_cycle();
        sample();
        check("rb0_ack",    32'(acc_ack),    32'd1);
        check("rb0_mem_rd", 32'(mem_rd),     32'd1);
        check("rb0_rvalid", 32'(acc_rvalid), 32'd0);
        next_cycle();
        acc_addr = 7'h21;
        sample();
        check("rb1_done",   32'(acc_done),   32'd1);
        check("rb1_rvalid", 32'(acc_rvalid), 32'd1);
        check("rb1_rdata",  acc_rdata,       32'h55);
        next_cycle();
        acc_req = 1'b0;
        sample();
        check("rb2_gnt",    32'(acc_gnt),    32'd0);
        check("rb2_rvalid", 32'(acc_rvalid), 32'd1);
        check("rb2_rdata",  acc_rdata,       32'h66);
        next_cycle();
        sample();
        check("rb3_rvalid", 32'(acc_rvalid), 32'd0);

        // CPU busy every cycle while the accelerator requests.
        next_cycle();
        acc_req = 1'b1; acc_wr = 1'b1; acc_len = 4'd2;
        acc_addr = 7'h30; acc_wdata = 32'h77;
        cpu_rd = 1'b1; cpu_addr = 7'h12;
        sample();
        check("sv_n_gnt",   32'(acc_gnt), 32'd0);
        check("sv_n_rdata", cpu_rdata,    32'hA2);
`ifdef DMEM_ARB_STARVE_EN
        for (int i = 1; i < 5; i++) begin
            next_cycle();
            sample();
            check("sv_wait_gnt",   32'(acc_gnt),   32'd0);
            check("sv_wait_stall", 32'(cpu_stall), 32'd0);
            check("sv_wait_rdata", cpu_rdata,      32'hA2);
        end
`else
        for (int i = 1; i < 8; i++) begin
            next_cycle();
            sample();
            check("sv_wait_gnt",   32'(acc_gnt),   32'd0);
            check("sv_wait_stall", 32'(cpu_stall), 32'd0);
            check("sv_wait_rdata", cpu_rdata,      32'hA2);
        end
        next_cycle();
        cpu_rd = 1'b0;
        sample();
        check("sv_idle_gnt", 32'(acc_gnt), 32'd0);
`endif
        // Granted; the CPU now issues a store that must wait.
        next_cycle();
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 7'h40; cpu_wdata = 32'hBEEF;
        sample();
        check("sv_g_gnt",   32'(acc_gnt),   32'd1);
        check("sv_g_stall", 32'(cpu_stall), 32'd1);
        check("sv_g_addr",  32'(mem_addr),  32'h30);
        check("sv_g_rdata", cpu_rdata,      32'd0);
        next_cycle();
        acc_addr = 7'h31; acc_wdata = 32'h78;
        sample();
        check("sv_g_done",   32'(acc_done),  32'd1);
        check("sv_g_stall2", 32'(cpu_stall), 32'd1);
        check("sv_g_wdata",  mem_wdata,      32'h78);
        next_cycle();
        acc_req = 1'b0;
        sample();
        check("sv_st_gnt",   32'(acc_gnt),   32'd0);
        check("sv_st_stall", 32'(cpu_stall), 32'd0);
        check("sv_st_wr",    32'(mem_wr),    32'd1);
        check("sv_st_addr",  32'(mem_addr),  32'h40);
        next_cycle();
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 7'h40;
        sample();
        check("sv_st_landed", cpu_rdata, 32'hBEEF);
        next_cycle();
        cpu_addr = 7'h30;
        sample();
        check("sv_acc_landed", cpu_rdata, 32'h77);

        // acc_len = 0 behaves as a single beat.
        next_cycle();
        cpu_rd = 1'b0;
        acc_req = 1'b1; acc_wr = 1'b1; acc_len = 4'd0;
        acc_addr = 7'h50; acc_wdata = 32'h11;
        sample();
        check("l0_req_gnt", 32'(acc_gnt), 32'd0);
        next_cycle();
        sample();
        check("l0_ack",  32'(acc_ack),  32'd1);
        check("l0_done", 32'(acc_done), 32'd1);
        next_cycle();
        acc_req = 1'b0;
        sample();
        check("l0_after_gnt", 32'(acc_gnt), 32'd0);

        // acc_len = 15 is clamped to 8 beats.
        next_cycle();
        acc_req = 1'b1; acc_len = 4'd15; acc_addr = 7'h60;
        sample();
        check("l15_req_gnt", 32'(acc_gnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            acc_addr = 7'h60 + 7'(i);
            sample();
            check("l15_ack",  32'(acc_ack),  32'd1);
            check("l15_done", 32'(acc_done), (i == 7) ? 32'd1 : 32'd0);
        end
        next_cycle();
        acc_req = 1'b0;
        sample();
        check("l15_after_gnt", 32'(acc_gnt), 32'd0);
        check("l15_after_ack", 32'(acc_ack), 32'd0);

        // Abort after 2 of 6 beats.
        next_cycle();
        acc_req = 1'b1; acc_len = 4'd6; acc_addr = 7'h70;
        sample();
        check("ab_req_gnt", 32'(acc_gnt), 32'd0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            sample();
            check("ab_ack",  32'(acc_ack),  32'd1);
            check("ab_done", 32'(acc_done), 32'd0);
        end
        next_cycle();
        acc_req = 1'b0;
        sample();
        check("ab_drop_gnt",  32'(acc_gnt),  32'd1);
        check("ab_drop_ack",  32'(acc_ack),  32'd0);
        check("ab_drop_done", 32'(acc_done), 32'd0);
        check("ab_drop_wr",   32'(mem_wr),   32'd0);
        next_cycle();
        sample();
        check("ab_idle_gnt", 32'(acc_gnt), 32'd0);

        // Reset during beat 3 of an 8-beat read burst.
        next_cycle();
        acc_req = 1'b1; acc_wr = 1'b0; acc_len = 4'd8; acc_addr = 7'h20;
        sample();
        check("rm_req_gnt", 32'(acc_gnt), 32'd0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            sample();
            check("rm_ack", 32'(acc_ack), 32'd1);
        end
        next_cycle();
        rst_n = 1'b0;
        sample();
        check("rm_b3_ack",    32'(acc_ack),    32'd1);
        check("rm_b3_rvalid", 32'(acc_rvalid), 32'd1);
        check("rm_b3_rdata",  acc_rdata,       32'h55);
        next_cycle();
        rst_n = 1'b1; acc_req = 1'b0; cpu_rd = 1'b1; cpu_addr = 7'h21;
        sample();
        check("rm_gnt",    32'(acc_gnt),    32'd0);
        check("rm_rvalid", 32'(acc_rvalid), 32'd0);
        check("rm_rdata",  acc_rdata,       32'd0);
        check("rm_stall",  32'(cpu_stall),  32'd0);
        check("rm_mem_rd", 32'(mem_rd),     32'd1);
        check("rm_addr",   32'(mem_addr),   32'h21);
        check("rm_cpu_rd", cpu_rdata,       32'h66);
        next_cycle();
        cpu_rd = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
